// File: rtl/id_ex_stage.sv
// =============================================================================
// id_ex_stage
// -----------------------------------------------------------------------------
// Decode-to-execute pipeline register of the 5-stage RV32I core.
//
// The register captures the ID-stage instruction on every advancing edge:
//   - both register-file read operands,
//   - the immediate,
//   - the PC,
//   - the opaque decoded-control bundle.
// It presents them to EX one cycle later.
//
// The stage also:
//   - detects load-use hazards against the instruction currently in EX,
//   - stalls IF/ID while EX applies back-pressure,
//   - inserts a bubble on a load-use hazard or on a branch/jump flush.
//
// Parameters
//   XLEN    datapath width (PC, operands, immediate)
//   CTRL_W  width of the decoded-control bundle
//
// Ports
//   clk, rst_n                 rising-edge clock, asynchronous active-low reset
//   id_valid                   ID holds a real instruction
//   id_pc, id_imm              PC and sign-extended immediate of the ID instruction
//   id_r1_idx, id_r2_idx       source register indices
//   id_use_rs1, id_use_rs2     instruction actually reads rs1 / rs2
//   id_reg1_data, id_reg2_data register-file read data (already WB-bypassed)
//   id_ctrl                    decoded control bundle
//   id_rd_idx, id_rd_wr        destination index and write enable
//   id_is_load                 instruction is a load
//   ex_ready                   EX accepts/retires its instruction this cycle
//   flush                      taken branch/jump in EX, kill the ID instruction
//   id_stall                   hold PC and IF/ID (combinational)
//   ex_*                       registered copies presented to EX
//
// Optional build macro
//   ID_EX_PERF_CNT_EN  when defined, adds two 32-bit wrapping counters:
//     perf_stall_cycles  cycles with id_stall=1
//     perf_bubbles       bubbles inserted by a hazard or a flush
// =============================================================================
module id_ex_stage #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   // ID-stage instruction
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [4:0]        id_r1_idx,
   input  logic [4:0]        id_r2_idx,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [XLEN-1:0]   id_reg1_data,
   input  logic [XLEN-1:0]   id_reg2_data,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [4:0]        id_rd_idx,
   input  logic              id_rd_wr,
   input  logic              id_is_load,
   // pipeline control
   input  logic              ex_ready,
   input  logic              flush,
   output logic              id_stall,
   // EX-stage view
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_rs1_data,
   output logic [XLEN-1:0]   ex_rs2_data,
   output logic [XLEN-1:0]   ex_imm,
   output logic [4:0]        ex_r1_idx,
   output logic [4:0]        ex_r2_idx,
   output logic [4:0]        ex_rd_idx,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic              ex_rd_wr,
   output logic              ex_is_load
`ifdef ID_EX_PERF_CNT_EN
   ,
   output logic [31:0]       perf_stall_cycles,
   output logic [31:0]       perf_bubbles
`endif
);

   // ------------------------------------------------------------------------
   // Pipeline state
   // ------------------------------------------------------------------------
   logic              ex_valid_q,   ex_valid_d;
   logic [XLEN-1:0]   ex_pc_q,      ex_pc_d;
   logic [XLEN-1:0]   ex_rs1_q,     ex_rs1_d;
   logic [XLEN-1:0]   ex_rs2_q,     ex_rs2_d;
   logic [XLEN-1:0]   ex_imm_q,     ex_imm_d;
   logic [4:0]        ex_r1_idx_q,  ex_r1_idx_d;
   logic [4:0]        ex_r2_idx_q,  ex_r2_idx_d;
   logic [4:0]        ex_rd_idx_q,  ex_rd_idx_d;
   logic [CTRL_W-1:0] ex_ctrl_q,    ex_ctrl_d;
   logic              ex_rd_wr_q,   ex_rd_wr_d;
   logic              ex_is_load_q, ex_is_load_d;

   // ------------------------------------------------------------------------
   // Hazard detection
   // ------------------------------------------------------------------------
   logic ex_load_pending;  // EX holds a load that will write a non-x0 register
   logic rs1_dep;
   logic rs2_dep;
   logic hazard;
   logic bubble;           // this edge inserts a bubble (flush or hazard)
   logic advance;          // this edge moves the ID instruction into EX

   always_comb begin
      ex_load_pending = ex_valid_q & ex_is_load_q & ex_rd_wr_q &
                        (ex_rd_idx_q != 5'd0);
      rs1_dep         = id_use_rs1 & (id_r1_idx == ex_rd_idx_q);
      rs2_dep         = id_use_rs2 & (id_r2_idx == ex_rd_idx_q);
      hazard          = ex_load_pending & id_valid & (rs1_dep | rs2_dep);

      // Flush wins over everything.
      // A stalled EX or a hazard freezes ID.
      // Reset is folded in so that IF/ID is never held while the core is
      // in reset, even though ex_ready may be low then.
      id_stall = rst_n & ~flush & (hazard | ~ex_ready);

      bubble  = flush | (ex_ready & hazard);
      advance = ~flush & ex_ready & ~hazard;
   end

   // ------------------------------------------------------------------------
   // Next-state
   //
   // Priority: flush, then back-pressure hold, then hazard bubble, then
   // advance.
   //
   // On a bubble only the three qualifying bits are cleared. The data
   // fields keep their previous value to avoid needless toggling, since
   // they are don't-care while ex_valid is low.
   // ------------------------------------------------------------------------
   always_comb begin
      ex_valid_d   = ex_valid_q;
      ex_pc_d      = ex_pc_q;
      ex_rs1_d     = ex_rs1_q;
      ex_rs2_d     = ex_rs2_q;
      ex_imm_d     = ex_imm_q;
      ex_r1_idx_d  = ex_r1_idx_q;
      ex_r2_idx_d  = ex_r2_idx_q;
      ex_rd_idx_d  = ex_rd_idx_q;
      ex_ctrl_d    = ex_ctrl_q;
      ex_rd_wr_d   = ex_rd_wr_q;
      ex_is_load_d = ex_is_load_q;

      if (bubble) begin
         ex_valid_d   = 1'b0;
         ex_rd_wr_d   = 1'b0;
         ex_is_load_d = 1'b0;
      end else if (advance) begin
         ex_valid_d   = id_valid;
         ex_pc_d      = id_pc;
         ex_rs1_d     = id_reg1_data;
         ex_rs2_d     = id_reg2_data;
         ex_imm_d     = id_imm;
         ex_r1_idx_d  = id_r1_idx;
         ex_r2_idx_d  = id_r2_idx;
         ex_rd_idx_d  = id_rd_idx;
         ex_ctrl_d    = id_ctrl;
         // A non-instruction must never write back or look like a load to
         // the next hazard check.
         ex_rd_wr_d   = id_rd_wr & id_valid;
         ex_is_load_d = id_is_load & id_valid;
      end
      // Otherwise EX is back-pressured: everything holds.
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q   <= 1'b0;
         ex_pc_q      <= '0;
         ex_rs1_q     <= '0;
         ex_rs2_q     <= '0;
         ex_imm_q     <= '0;
         ex_r1_idx_q  <= '0;
         ex_r2_idx_q  <= '0;
         ex_rd_idx_q  <= '0;
         ex_ctrl_q    <= '0;
         ex_rd_wr_q   <= 1'b0;
         ex_is_load_q <= 1'b0;
      end else begin
         ex_valid_q   <= ex_valid_d;
         ex_pc_q      <= ex_pc_d;
         ex_rs1_q     <= ex_rs1_d;
         ex_rs2_q     <= ex_rs2_d;
         ex_imm_q     <= ex_imm_d;
         ex_r1_idx_q  <= ex_r1_idx_d;
         ex_r2_idx_q  <= ex_r2_idx_d;
         ex_rd_idx_q  <= ex_rd_idx_d;
         ex_ctrl_q    <= ex_ctrl_d;
         ex_rd_wr_q   <= ex_rd_wr_d;
         ex_is_load_q <= ex_is_load_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign ex_valid    = ex_valid_q;
   assign ex_pc       = ex_pc_q;
   assign ex_rs1_data = ex_rs1_q;
   assign ex_rs2_data = ex_rs2_q;
   assign ex_imm      = ex_imm_q;
   assign ex_r1_idx   = ex_r1_idx_q;
   assign ex_r2_idx   = ex_r2_idx_q;
   assign ex_rd_idx   = ex_rd_idx_q;
   assign ex_ctrl     = ex_ctrl_q;
   // Already cleared by every bubble; the extra gate keeps the invariant
   // explicit for downstream write-back logic.
   assign ex_rd_wr    = ex_rd_wr_q & ex_valid_q;
   assign ex_is_load  = ex_is_load_q & ex_valid_q;

`ifdef ID_EX_PERF_CNT_EN
   // ------------------------------------------------------------------------
   // Performance counters (free-running, wrap at 2^32)
   // ------------------------------------------------------------------------
   logic [31:0] stall_cnt_q,  stall_cnt_d;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;

   always_comb begin
      stall_cnt_d  = stall_cnt_q  + 32'(id_stall);
      bubble_cnt_d = bubble_cnt_q + 32'(bubble);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign perf_stall_cycles = stall_cnt_q;
   assign perf_bubbles      = bubble_cnt_q;
`endif

endmodule
